// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment constants and hex encoding table
// Purpose: digit count, blank pattern, segment type and the active-low
//          {g,f,e,d,c,b,a} encoding of the sixteen hex digits.
// Ports:   none (package)
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low segment decoder
// Purpose: table lookup of one nibble into the {g..a} segment pattern.
// Ports:   nibble (in, 4)  - hex digit value
//          seg    (out, 7) - active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/fpga_out_display.sv
// rtl/fpga_out_display.sv - four-digit multiplexed hex display of the processor output word
// Purpose: captures a 16-bit word on Load and scans it across a common-anode
//          seven-segment display, one digit per REFRESH_DIV clock cycles.
// Ports:   CLK    (in, 1)   - system clock, rising edge
//          reset  (in, 1)   - asynchronous active-high reset
//          DataIn (in, 16)  - word to display
//          Load   (in, 1)   - capture DataIn on this edge
//          Seg    (out, 7)  - active-low segments {g..a}, registered
//          Dp     (out, 1)  - active-low decimal point, held off
//          An     (out, 4)  - active-low one-hot anodes, An[0] = low nibble
module fpga_out_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] DataIn,
  input  logic        Load,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic [3:0]  An
);

  localparam int          PW      = $clog2(REFRESH_DIV);
  localparam int          IW      = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  logic [15:0]   shown;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic          tick;
  logic [3:0]    nibble;
  seg_t          hex_seg;
  logic          blank;

  assign tick = (pre == PRE_MAX);

  // Single decoder on the currently selected nibble.
  assign nibble = shown[{idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 always shows so an all-zero word still reads "0".
  always_comb begin
    blank = 1'b0;
    if (BLANK_LEADING != 0) begin
      case (idx)
        2'd1:    blank = (shown[15:4]  == 12'h000);
        2'd2:    blank = (shown[15:8]  == 8'h00);
        2'd3:    blank = (shown[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
    end
  end

  // Outputs are driven from the pre-edge idx/shown, so a load or digit
  // advance becomes visible on the following edge, never as a mixed digit.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      shown <= 16'h0000;
      pre   <= '0;
      idx   <= '0;
      An    <= 4'b1111;
      Seg   <= SEG_BLANK;
      Dp    <= 1'b1;
    end else begin
      if (Load) begin
        shown <= DataIn;
      end
      if (tick) begin
        pre <= '0;
        idx <= idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      An  <= ~(4'b0001 << idx);
      Seg <= blank ? SEG_BLANK : hex_seg;
      Dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpga_out_display.sv
// tb/tb_fpga_out_display.sv - directed table-driven bench for fpga_out_display
module tb_fpga_out_display;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        load;
  logic [6:0]  seg_n, seg_b;
  logic        dp_n, dp_b;
  logic [3:0]  an_n, an_b;

  int total = 0;
  int bad   = 0;

  fpga_out_display #(.REFRESH_DIV(4), .BLANK_LEADING(0)) u_dut (
    .CLK(clk), .reset(reset), .DataIn(din), .Load(load),
    .Seg(seg_n), .Dp(dp_n), .An(an_n)
  );

  fpga_out_display #(.REFRESH_DIV(4), .BLANK_LEADING(1)) u_dut_blank (
    .CLK(clk), .reset(reset), .DataIn(din), .Load(load),
    .Seg(seg_b), .Dp(dp_b), .An(an_b)
  );

  initial clk = 1'b0;
  always #15 clk = ~clk;

  typedef struct {
    int          n;
    logic        ld;
    logic [15:0] d;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [6:0]  segb;
  } vec_t;

  vec_t vecs [28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] an,
                         input logic [6:0] seg, input logic [6:0] segb);
    chk({tag, " an"},       32'(an_n),  32'(an));
    chk({tag, " an_blank"}, 32'(an_b),  32'(an));
    chk({tag, " seg"},      32'(seg_n), 32'(seg));
    chk({tag, " seg_blank"},32'(seg_b), 32'(segb));
    chk({tag, " dp"},       32'(dp_n),  32'd1);
    chk({tag, " dp_blank"}, 32'(dp_b),  32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rows: cycles, Load, DataIn, expected An, Seg (no blanking), Seg (blanking)
    vecs[0]  = '{1, 1'b1, 16'h1234, 4'hE, 7'h40, 7'h40};
    vecs[1]  = '{3, 1'b0, 16'h0000, 4'hE, 7'h19, 7'h19};
    vecs[2]  = '{4, 1'b0, 16'h0000, 4'hD, 7'h30, 7'h30};
    vecs[3]  = '{4, 1'b0, 16'h0000, 4'hB, 7'h24, 7'h24};
    vecs[4]  = '{4, 1'b0, 16'h0000, 4'h7, 7'h79, 7'h79};
    vecs[5]  = '{1, 1'b1, 16'hABCD, 4'hE, 7'h19, 7'h19};
    vecs[6]  = '{3, 1'b0, 16'hFFFF, 4'hE, 7'h21, 7'h21};
    vecs[7]  = '{4, 1'b0, 16'hFFFF, 4'hD, 7'h46, 7'h46};
    vecs[8]  = '{4, 1'b0, 16'hFFFF, 4'hB, 7'h03, 7'h03};
    vecs[9]  = '{4, 1'b0, 16'hFFFF, 4'h7, 7'h08, 7'h08};
    vecs[10] = '{1, 1'b1, 16'hFFFF, 4'hE, 7'h21, 7'h21};
    vecs[11] = '{3, 1'b0, 16'hFFFF, 4'hE, 7'h0E, 7'h0E};
    vecs[12] = '{1, 1'b1, 16'h0001, 4'hD, 7'h0E, 7'h0E};
    vecs[13] = '{3, 1'b0, 16'h0000, 4'hD, 7'h40, 7'h7F};
    vecs[14] = '{4, 1'b0, 16'h0000, 4'hB, 7'h40, 7'h7F};
    vecs[15] = '{4, 1'b0, 16'h0000, 4'h7, 7'h40, 7'h7F};
    vecs[16] = '{4, 1'b0, 16'h0000, 4'hE, 7'h79, 7'h79};
    vecs[17] = '{1, 1'b1, 16'h0000, 4'hD, 7'h40, 7'h7F};
    vecs[18] = '{3, 1'b0, 16'h0000, 4'hD, 7'h40, 7'h7F};
    vecs[19] = '{4, 1'b0, 16'h0000, 4'hB, 7'h40, 7'h7F};
    vecs[20] = '{4, 1'b0, 16'h0000, 4'h7, 7'h40, 7'h7F};
    vecs[21] = '{4, 1'b0, 16'h0000, 4'hE, 7'h40, 7'h40};
    vecs[22] = '{3, 1'b0, 16'h0000, 4'hD, 7'h40, 7'h7F};
    vecs[23] = '{1, 1'b1, 16'h0F00, 4'hD, 7'h40, 7'h7F};
    vecs[24] = '{4, 1'b0, 16'h0000, 4'hB, 7'h0E, 7'h0E};
    vecs[25] = '{4, 1'b0, 16'h0000, 4'h7, 7'h40, 7'h7F};
    vecs[26] = '{4, 1'b0, 16'h0000, 4'hE, 7'h40, 7'h40};
    vecs[27] = '{4, 1'b0, 16'h0000, 4'hD, 7'h40, 7'h40};

    reset = 1'b1;
    load  = 1'b0;
    din   = 16'h0000;
    #5;
    chk_all("reset_init", 4'hF, 7'h7F, 7'h7F);
    step();
    chk_all("reset_hold", 4'hF, 7'h7F, 7'h7F);
    reset = 1'b0;

    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < vecs[r].n; c++) begin
        load = vecs[r].ld;
        din  = vecs[r].d;
        step();
        chk_all($sformatf("row%0d_c%0d", r, c), vecs[r].an, vecs[r].seg, vecs[r].segb);
      end
    end

    // Reset mid-scan: load a nonzero word, then reset between edges.
    load = 1'b1;
    din  = 16'h1234;
    step();
    load = 1'b0;
    step();
    step();
    #7;
    reset = 1'b1;
    #1;
    chk_all("midreset_async", 4'hF, 7'h7F, 7'h7F);
    step();
    chk_all("midreset_edge", 4'hF, 7'h7F, 7'h7F);
    reset = 1'b0;

    // Old word discarded, scan restarts at digit 0 with a full slot.
    for (int c = 0; c < 4; c++) begin
      step();
      chk_all($sformatf("post_reset_c%0d", c), 4'hE, 7'h40, 7'h40);
    end
    step();
    chk_all("post_reset_adv", 4'hD, 7'h40, 7'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_out_display.md
# fpga_out_display

Output-side peripheral that consumes the processor's 16-bit `FPGAOut` word and shows it as four hexadecimal digits on a time-multiplexed, common-anode seven-segment display. It sits directly downstream of the `integration3` processor at the board top level. A load strobe controls when a new word is captured. Typical sources for the strobe are `MemWriteTest` or a constant 1. Between loads, the captured word is held and refreshed continuously.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles per digit slot. Legal range is ≥ 2. Simulation uses 4.
- `BLANK_LEADING`, default 0: when 1, leading zero digits are blanked. Digit 0 is never blanked.

Ports:
- `CLK`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `DataIn`  in  16: word to display, connected to `FPGAOut`.
- `Load`  in  1: capture `DataIn` on the rising edge when high.
- `Seg`  out  7: segments `{g,f,e,d,c,b,a}`, active-low, registered.
- `Dp`  out  1: decimal point, active-low, registered. Always 1 (off).
- `An`  out  4: digit anodes, active-low, one-hot-low, registered. `An[0]` is the least significant nibble.

## Operation
- **Held register `shown[15:0]`**
  - On `Load`=1: `shown` ← `DataIn`.
  - Otherwise `shown` holds its value.
- **Prescaler `pre`** (width `$clog2(REFRESH_DIV)`)
  - Increments every cycle.
  - On reaching `REFRESH_DIV-1`, it wraps to 0 and asserts a one-cycle `tick`.
- **Digit index `idx[1:0]`**
  - Advances on `tick`: 0→1→2→3→0, modulo-4 wrap.
- **Output register update** (every cycle, from current `idx` and `shown`):
  - `An` ← all ones except bit `idx` = 0.
  - `Seg` ← hex encoding of `shown[4*idx +: 4]`.
  - If the digit is blanked, `Seg` ← `7'h7F`.
- **Blanking** (only when `BLANK_LEADING`=1): digit k>0 is blanked iff `shown[15:4k]` == 0.
- **Hex encoding** (active-low `{g..a}`):
  - 0=`1000000`, 1=`1111001`, 2=`0100100`, 3=`0110000`
  - 4=`0011001`, 5=`0010010`, 6=`0000010`, 7=`1111000`
  - 8=`0000000`, 9=`0010000`, A=`0001000`, b=`0000011`
  - C=`1000110`, d=`0100001`, E=`0000110`, F=`0001110`
- **Reset** (asynchronous, takes effect immediately):
  - `shown`=0, `pre`=0, `idx`=0.
  - `An`=`4'b1111`, `Seg`=`7'h7F`, `Dp`=1.

## Timing
- **Load latency**: with `Load` high at edge N, `shown` updates at N. `Seg` reflects the new value for the active digit at edge N+1.
- **Digit slot**: exactly `REFRESH_DIV` cycles per digit. Full scan period is `4*REFRESH_DIV` cycles.
- **First cycle after reset release**:
  - First rising edge: `An`=`1110`, `Seg`=encode(0)=`1000000`.
  - `idx` first advances after `REFRESH_DIV` edges.
- **Load and tick on the same edge**: both take effect. The next edge drives the new digit with the new data. No stale or mixed digit is output for more than one cycle.
- **Consecutive `Load` cycles**: the last captured value wins. There is no handshake and no back-pressure, and `Load` may be held high permanently.
- **Reset mid-scan**:
  - Outputs blank immediately.
  - Scanning restarts at digit 0 with `pre`=0.
  - The previous `shown` is discarded.
- **Anodes**: exactly one anode is low at any time outside reset.

## Structure
- Shared package `seg7_pkg`:
  - `NUM_DIGITS`=4.
  - `SEG_BLANK`=`7'h7F`.
  - Typedef `seg_t` (logic [6:0]).
  - The 16-entry hex encoding constant array.
- Sub-module `hex_to_seg7`: combinational nibble → `seg_t`. It is instantiated once, on the muxed nibble.
- Top-level placement: `DataIn`←`FPGAOut`, `Load`←`MemWriteTest` (or 1'b1), sharing `CLK` and `reset` with the processor.

## Test plan
All scenarios use `REFRESH_DIV`=4 and a 30 ns clock.
- **Reset values**: assert `reset` mid-cycle → `An`=`1111`, `Seg`=`7F`, `Dp`=1 immediately. On release, the first edge gives `An`=`1110`, `Seg`=`1000000`.
- **Scan of a loaded word**: pulse `Load` with `DataIn`=`16'h1234` → over the next 16 cycles, `An` steps `1110`/`1101`/`1011`/`0111` for 4 cycles each. `Seg` reads 4=`0011001`, 3=`0110000`, 2=`0100100`, 1=`1111001`.
- **Hold after load**: after loading `16'hABCD`, drive `DataIn`=`16'hFFFF` with `Load`=0 → display stays d/C/b/A. The next `Load` pulse switches it to F on all digits, with the change visible one cycle after the edge.
- **Leading-zero blanking**: with `BLANK_LEADING`=1, load `16'h0001` → digits 1–3 give `Seg`=`7F`, digit 0 gives `1111001`. Loading `16'h0000` shows only digit 0 = `1000000`.
- **Load coincident with tick**: assert `Load` (`DataIn`=`16'h0F00`) on the edge where `idx` goes 1→2 → the next-cycle `Seg` is F=`0001110`, not the previous digit-2 value.
- **Processor output (gcd)**: connected to `integration3` running gcd(15,32) with `Load`=1 → after the program completes, digit 0 shows 1 and digits 1–3 show 0.
